montgomery_reduce: RTL and testbench

MONTGOMERY_REDUCE -- requirements
Module: montgomery_reduce

---
 rtl/montgomery_reduce.sv | 132 +++++++++++++
 tb/tb_montgomery_reduce.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_reduce.sv
// -----------------------------------------------------------------------------
// montgomery_reduce
//   Three-stage pipelined Montgomery reduction for Kyber and Dilithium
//   coefficients.
//   It computes coef = product * R^-1 mod q, giving a canonical result in
//   [0, q-1].
//   The modulus is chosen per item, and mode travels with the data through
//   every stage.
//   The pipeline uses a single global stall: all stages advance together when
//   the output register is empty or downstream is ready.
//
// Parameters
//   PROD_WIDTH  width of the signed product input
//   COEF_WIDTH  width of the unsigned reduced coefficient output
//
// Ports
//   clk_i      clock, rising edge
//   rstn_i     asynchronous active-low reset
//   mode_i     0 = Kyber (q=3329, R=2^16), 1 = Dilithium (q=8380417, R=2^32)
//   valid_i    product_i / mode_i valid
//   ready_o    input accepted this cycle (equals the pipeline enable)
//   product_i  signed two's-complement product
//   valid_o    coef_o valid
//   ready_i    downstream accepts coef_o
//   coef_o     reduced coefficient, zero-extended
// -----------------------------------------------------------------------------
module montgomery_reduce #(
  parameter int PROD_WIDTH = 48,
  parameter int COEF_WIDTH = 24
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  mode_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [PROD_WIDTH-1:0] product_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [COEF_WIDTH-1:0] coef_o
);

  // t*q needs up to 32+24 signed bits; one extra bit keeps a - t*q exact.
  localparam int D_W = ((PROD_WIDTH > 56) ? PROD_WIDTH : 56) + 1;

  localparam logic [31:0]            QINV_K = 32'hFFFF_F301;  // -3327
  localparam logic [31:0]            QINV_D = 32'd58728449;
  localparam logic signed [D_W-1:0]  Q_K    = D_W'(3329);
  localparam logic signed [D_W-1:0]  Q_D    = D_W'(8380417);

  // Canonicalise: r lies in (-q, q), so a single conditional add of q is
  // enough to land in [0, q-1].
  function automatic logic [COEF_WIDTH-1:0] f_canon(
    input logic signed [D_W-1:0] r,
    input logic signed [D_W-1:0] q
  );
    return COEF_WIDTH'((r < 0) ? (r + q) : r);
  endfunction

  logic                          en;

  logic                          vld_p0;
  logic                          mode_p0;
  logic signed [PROD_WIDTH-1:0]  a_p0;
  logic signed [31:0]            t_p0;

  logic                          vld_p1;
  logic                          mode_p1;
  logic signed [D_W-1:0]         d_p1;

  logic                          vld_p2;
  logic [COEF_WIDTH-1:0]         coef_p2;

  logic [31:0]                   qinv_sel;
  logic [31:0]                   m_lo;
  logic signed [31:0]            t_nxt;
  logic signed [D_W-1:0]         a_ext;
  logic signed [D_W-1:0]         t_ext;
  logic signed [D_W-1:0]         q_p0;
  logic signed [D_W-1:0]         d_nxt;
  logic signed [D_W-1:0]         r_nxt;
  logic signed [D_W-1:0]         q_p1;
  logic [COEF_WIDTH-1:0]         coef_nxt;

  assign en      = !vld_p2 || ready_i;
  assign ready_o = en;
  assign valid_o = vld_p2;
  assign coef_o  = coef_p2;

  // ---- input -> p0: t = signed low log2(R) bits of (a mod R) * QINV
  // Only the low 32 bits of the product are ever needed, so the multiply is
  // kept at 32 bits; Kyber then takes the signed low 16 of that.
  assign qinv_sel = mode_i ? QINV_D : QINV_K;
  assign m_lo     = product_i[31:0] * qinv_sel;
  assign t_nxt    = mode_i ? $signed(m_lo)
                           : $signed({{16{m_lo[15]}}, m_lo[15:0]});

  // ---- p0 -> p1: d = a - t*q (low log2(R) bits of d are zero by construction)
  assign a_ext = {{(D_W-PROD_WIDTH){a_p0[PROD_WIDTH-1]}}, a_p0};
  assign t_ext = {{(D_W-32){t_p0[31]}}, t_p0};
  assign q_p0  = mode_p0 ? Q_D : Q_K;
  assign d_nxt = a_ext - (t_ext * q_p0);

  // ---- p1 -> p2: r = d >>> log2(R), then fold negatives into [0, q-1]
  assign r_nxt    = mode_p1 ? (d_p1 >>> 32) : (d_p1 >>> 16);
  assign q_p1     = mode_p1 ? Q_D : Q_K;
  assign coef_nxt = f_canon(r_nxt, q_p1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_p0  <= 1'b0;
      mode_p0 <= 1'b0;
      a_p0    <= '0;
      t_p0    <= '0;
      vld_p1  <= 1'b0;
      mode_p1 <= 1'b0;
      d_p1    <= '0;
      vld_p2  <= 1'b0;
      coef_p2 <= '0;
    end else if (en) begin
      vld_p0  <= valid_i;
      mode_p0 <= mode_i;
      a_p0    <= product_i;
      t_p0    <= t_nxt;
      vld_p1  <= vld_p0;
      mode_p1 <= mode_p0;
      d_p1    <= d_nxt;
      vld_p2  <= vld_p1;
      coef_p2 <= coef_nxt;
    end
  end

endmodule

// File: tb/tb_montgomery_reduce.sv
module tb_montgomery_reduce;

  localparam int PW = 48;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          mode_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [PW-1:0] product_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [CW-1:0] coef_o;

  montgomery_reduce #(.PROD_WIDTH(PW), .COEF_WIDTH(CW)) dut (
    .clk_i    (clk),
    .rstn_i   (rstn_i),
    .mode_i   (mode_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .product_i(product_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .coef_o   (coef_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mode;
    longint      prod;
    logic [23:0] exp;
  } vec_t;

  typedef struct {
    logic [23:0] exp;
    int          acc_cyc;
    bit          chk_lat;
  } sb_t;

  sb_t         sbq[$];
  sb_t         cur;
  vec_t        tbl[14];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rand_rdy = 1'b0;
  bit          rdy_force = 1'b1;
  bit          prev_stall = 1'b0;
  logic [23:0] prev_coef = '0;
  longint      rinv_k;
  longint      rinv_d;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: forced level or random backpressure.
  always begin
    @(posedge clk);
    #2;
    ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  function automatic longint modpow(input longint b, input longint e, input longint m);
    longint r = 1;
    longint bb = b % m;
    longint ee = e;
    while (ee > 0) begin
      if (ee[0]) r = (r * bb) % m;
      bb = (bb * bb) % m;
      ee = ee >>> 1;
    end
    return r;
  endfunction

  function automatic logic [23:0] ref_mod(input bit m, input longint a);
    longint q  = m ? 64'sd8380417 : 64'sd3329;
    longint ri = m ? rinv_d : rinv_k;
    longint am = a % q;
    if (am < 0) am = am + q;
    return 24'((am * ri) % q);
  endfunction

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (rstn_i) begin
      if (prev_stall) begin
        checks++;
        if (!(valid_o === 1'b1 && coef_o === prev_coef)) begin
          errors++;
          $display("FAIL hold_stable valid_o=%0b coef_o=%0d required valid_o=1 coef_o=%0d",
                   valid_o, coef_o, prev_coef);
        end
      end
      if (valid_o && ready_i) begin
        prev_stall = 1'b0;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output coef_o=%0d required no output", coef_o);
        end else begin
          cur = sbq.pop_front();
          if (coef_o !== cur.exp) begin
            errors++;
            $display("FAIL coef coef_o=%0d required %0d", coef_o, cur.exp);
          end
          if (cur.chk_lat) begin
            checks++;
            if (cyc - cur.acc_cyc != 3) begin
              errors++;
              $display("FAIL latency got %0d cycles required 3", cyc - cur.acc_cyc);
            end
          end
        end
      end else if (valid_o) begin
        checks++;
        if (ready_o !== 1'b0) begin
          errors++;
          $display("FAIL ready_o_stalled ready_o=%0b required 0", ready_o);
        end
        prev_stall = 1'b1;
        prev_coef  = coef_o;
      end else begin
        prev_stall = 1'b0;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Entered and left at posedge+1.
  task automatic push(input bit m, input longint p, input logic [23:0] e, input bit cl);
    bit ok = 1'b0;
    mode_i    = m;
    product_i = p[PW-1:0];
    valid_i   = 1'b1;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      sbq.push_back('{exp: e, acc_cyc: cyc, chk_lat: cl});
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout ready_o=%0b required 1 within 100 cycles", ready_o);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 300 && sbq.size() != 0; w++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", sbq.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (valid_o !== 1'b0 || coef_o !== '0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s valid_o=%0b coef_o=%0d ready_o=%0b required 0 0 1",
               tag, valid_o, coef_o, ready_o);
    end
  endtask

  initial begin
    longint mag;
    bit     m;

    rinv_k = modpow(modpow(2, 16, 3329), 3329 - 2, 3329);
    rinv_d = modpow(modpow(2, 32, 8380417), 8380417 - 2, 8380417);

    tbl[0]  = '{0, 64'sd65536, 24'd1};
    tbl[1]  = '{0, 64'sd1, 24'd169};
    tbl[2]  = '{0, -64'sd65536, 24'd3328};
    tbl[3]  = '{0, 64'sd0, 24'd0};
    tbl[4]  = '{0, 64'sd2, 24'd338};
    tbl[5]  = '{0, -64'sd1, 24'd3160};
    tbl[6]  = '{0, 64'sd3329, 24'd0};
    tbl[7]  = '{0, 64'sd109084671, 24'd3160};
    tbl[8]  = '{0, -64'sd109084671, 24'd169};
    tbl[9]  = '{1, 64'sd4294967296, 24'd1};
    tbl[10] = '{1, -64'sd4294967296, 24'd8380416};
    tbl[11] = '{1, 64'sd0, 24'd0};
    tbl[12] = '{1, 64'sd140733193388032, 24'd32767};
    tbl[13] = '{1, -64'sd140737488355328, 24'd8347649};

    // Reset state.
    #1;
    check_reset_outputs("reset_state");
    repeat (3) @(posedge clk);
    #1;
    rstn_i = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors back-to-back, 3-cycle latency each.
    foreach (tbl[i]) push(tbl[i].mode, tbl[i].prod, tbl[i].exp, 1'b1);
    drain();

    // Mixed-mode back-to-back.
    push(1'b0, 64'sd65536, 24'd1, 1'b1);
    push(1'b1, -64'sd4294967296, 24'd8380416, 1'b1);
    push(1'b0, 64'sd1, 24'd169, 1'b1);
    drain();

    // Stall: ready_i low for 4 cycles after the first output.
    fork
      begin
        for (int i = 0; i < 5; i++)
          push(i[0], longint'(1000 + i * 777), ref_mod(i[0], longint'(1000 + i * 777)), 1'b0);
      end
      begin
        for (int w = 0; w < 50; w++) begin
          @(negedge clk);
          if (valid_o) break;
        end
        @(posedge clk);
        #1;
        rdy_force = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rdy_force = 1'b1;
      end
    join
    drain();

    // Reset with three items in flight.
    push(1'b0, 64'sd65536, 24'd1, 1'b0);
    push(1'b1, 64'sd4294967296, 24'd1, 1'b0);
    push(1'b0, 64'sd1, 24'd169, 1'b0);
    rstn_i = 1'b0;
    #1;
    check_reset_outputs("reset_flush");
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_valid valid_o=%0b required 0", valid_o);
      end
    end
    @(posedge clk);
    #1;
    push(1'b0, 64'sd65536, 24'd1, 1'b1);
    drain();

    // Random traffic against the reference model.
    rand_rdy = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      m = bit'($urandom_range(0, 1));
      if (!m) mag = longint'($urandom_range(0, 109084671));
      else    mag = (longint'($urandom_range(0, 32767)) << 32) | longint'($urandom);
      if ($urandom_range(0, 1) == 1) mag = -mag;
      push(m, mag, ref_mod(m, mag), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
